uart_tx_fifo: RTL and testbench

//  Downstream stage of the USB OUT endpoint buffer. Accepts bytes from the endpoint with a

---
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of an 8N1 UART transmitter (LSB first).
// Bytes arrive on a valid/ready handshake and are queued. The transmitter
// pulls the head byte whenever it is idle, or at the end of a stop bit, so
// queued bytes leave as back-to-back frames with no idle gap between them.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 520,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_dat,
    input  logic                  in_val,
    output logic                  in_rdy,
    output logic                  tx,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int BW    = $clog2(CLK_DIV);
    localparam logic [BW-1:0]       BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [DEPTH_LOG2:0] FULL      = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_nxt;
    logic [BW-1:0]          baud_cnt, baud_nxt;
    logic [2:0]             bit_idx, bit_nxt;
    logic [7:0]             shift, shift_nxt;
    logic                   tx_nxt;
    logic                   push, pop;
    logic                   baud_done;
    logic [7:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
    logic [7:0]             head;

    // Ready comes only from the registered level, so a full FIFO refuses a
    // push even in a cycle where the transmitter pops.
    assign in_rdy    = (level != FULL);
    assign push      = in_val && in_rdy;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || (level != '0);
    assign baud_done = (baud_cnt == BAUD_LAST);

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Circular pointers and occupancy; simultaneous push and pop keep level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (!push && pop) begin
                level <= level - 1'b1;
            end
        end
    end

    // Transmitter state register; tx is registered so the line never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
        end
    end

    // Next-state logic: tx_nxt is the line level for the bit that starts at
    // the coming edge, so each bit lasts exactly CLK_DIV cycles.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = tx;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                baud_nxt = '0;
                if (level != '0) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt = bit_idx + 1'b1;
                        tx_nxt  = shift[1];
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_nxt = '0;
                    if (level != '0) begin
                        pop       = 1'b1;
                        shift_nxt = head;
                        state_nxt = START;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        tx_nxt    = 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with CLK_DIV=4, 16-deep FIFO.
// Accepted bytes are queued as expected output; a UART monitor decodes the tx
// line and compares each received byte with the head of that queue.
module tb_uart_tx_fifo;

    localparam int CLK_DIV = 4;
    localparam int DL2     = 4;

    logic           clk;
    logic           rst;
    logic [7:0]     in_dat;
    logic           in_val;
    logic           in_rdy;
    logic           tx;
    logic           busy;
    logic [DL2:0]   level;

    int             vec_count = 0;
    int             err_count = 0;
    logic [7:0]     exp_q[$];
    int             acc_total = 0;
    logic           last_acc = 1'b0;

    int             cyc = 0;
    logic           mon_active = 1'b0;
    int             mon_cnt = 0;
    logic           mon_prev = 1'b1;
    logic [7:0]     mon_byte = '0;
    int             last_start = 0;
    int             prev_start = 0;

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DEPTH_LOG2(DL2)) dut (
        .clk    (clk),
        .rst    (rst),
        .in_dat (in_dat),
        .in_val (in_val),
        .in_rdy (in_rdy),
        .tx     (tx),
        .busy   (busy),
        .level  (level)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one clock of input; a byte seen accepted (val && rdy before the
    // edge) becomes an expected output byte. Returns 1 unit after the edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d);
        in_val = v;
        in_dat = d;
        @(negedge clk);
        last_acc = v && in_rdy;
        if (last_acc) begin
            exp_q.push_back(d);
            acc_total++;
        end
        @(posedge clk);
        #1;
    endtask

    // Idle until the DUT drains, with a cycle budget.
    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        checkOutput("idle_timeout", busy, 0);
    endtask

    // UART monitor: on a falling line start a 40-cycle frame window, check the
    // line is steady inside each bit, sample mid-bit and score the byte.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                prev_start = last_start;
                last_start = cyc;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % 4 != 0) begin
                checkOutput("tx_steady", tx, mon_prev);
            end
            if (mon_cnt == 2) begin
                checkOutput("start_bit", tx, 0);
            end
            if (mon_cnt >= 6 && mon_cnt <= 34 && mon_cnt % 4 == 2) begin
                mon_byte[(mon_cnt - 6) / 4] = tx;
            end
            if (mon_cnt == 38) begin
                checkOutput("stop_bit", tx, 1);
                checkOutput("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    checkOutput("uart_byte", mon_byte, exp_q.pop_front());
                end
            end
            if (mon_cnt == 39) begin
                mon_active = 1'b0;
            end
        end
        mon_prev = tx;
    end

    // Directed scenarios followed by random traffic.
    initial begin
        int   lvl;
        logic popped;
        int   acc_before;
        int   guard;

        rst    = 1'b1;
        in_val = 1'b0;
        in_dat = 8'h00;
        #1;
        checkOutput("rst tx", tx, 1);
        checkOutput("rst level", level, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst in_rdy", in_rdy, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: single byte latency and frame length
        applyStimulus(1'b1, 8'h55);
        checkOutput("t1 tx_before", tx, 1);
        checkOutput("t1 level_push", level, 1);
        checkOutput("t1 busy_push", busy, 1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("t1 tx_fall", tx, 0);
        checkOutput("t1 level_pop", level, 0);
        repeat (39) applyStimulus(1'b0, 8'h00);
        checkOutput("t1 busy_hold", busy, 1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("t1 busy_fall", busy, 0);
        checkOutput("t1 tx_idle", tx, 1);

        // 2: two consecutive pushes give contiguous frames
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        applyStimulus(1'b0, 8'h00);
        wait_idle(200);
        checkOutput("t2 gap", last_start - prev_start, 40);

        // 3: fill from empty with in_val held for 18 cycles
        acc_before = acc_total;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 8'h10 + 8'(i));
        end
        checkOutput("t3 accepted", acc_total - acc_before, 17);
        checkOutput("t3 last_refused", last_acc, 0);
        checkOutput("t3 level_full", level, 16);
        checkOutput("t3 in_rdy", in_rdy, 0);

        // 4: push attempted on the pop cycle of a full FIFO is refused
        popped = 1'b0;
        for (int n = 0; n < 100 && !popped; n++) begin
            lvl = int'(level);
            applyStimulus(1'b1, 8'hC0);
            if (int'(level) < lvl) popped = 1'b1;
        end
        checkOutput("t4 pop_seen", popped, 1);
        checkOutput("t4 pop_refused", last_acc, 0);
        checkOutput("t4 level_15", level, 15);
        applyStimulus(1'b1, 8'hC1);
        checkOutput("t4 next_accepted", last_acc, 1);
        checkOutput("t4 level_16", level, 16);
        applyStimulus(1'b0, 8'h00);
        wait_idle(2000);

        // 5: reset in the middle of data bit 3 with five bytes queued
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'h31 + 8'(i));
        end
        in_val = 1'b0;
        repeat (13) applyStimulus(1'b0, 8'h00);
        checkOutput("t5 pre_level", level, 5);
        checkOutput("t5 pre_tx_bit3", tx, 0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("t5 rst_tx", tx, 1);
        checkOutput("t5 rst_level", level, 0);
        checkOutput("t5 rst_busy", busy, 0);
        checkOutput("t5 rst_in_rdy", in_rdy, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 8'hA5);
        applyStimulus(1'b0, 8'h00);
        wait_idle(200);
        checkOutput("t5 sb_drained", exp_q.size(), 0);

        // 6: random push/stall traffic alternating fill and drain phases
        acc_before = acc_total;
        guard = 0;
        while (acc_total - acc_before < 600 && guard < 40000) begin
            if ((guard / 500) % 2 == 0) begin
                applyStimulus($urandom_range(0, 1) == 1, 8'($urandom));
            end else begin
                applyStimulus($urandom_range(0, 31) == 0, 8'($urandom));
            end
            checkOutput("t6 level_max", level > 16, 0);
            guard++;
        end
        checkOutput("t6 bytes_sent", acc_total - acc_before >= 600, 1);
        applyStimulus(1'b0, 8'h00);
        wait_idle(2000);
        checkOutput("t6 sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
